mbr_frame_rx: RTL and testbench

Receive side of the MBR framing link. The block takes the 320 kHz bit strobe (i320), the active-low frame marker (iMBR) and the serial data line from the far end. It acquires frame alignment from the marker spacing, then deserializes each frame into a parallel word. It also reports lock status and framing errors to the downstream word processor.

---
 rtl/mbr_pkg.sv | 20 ++
 rtl/mbr_frame_rx_if.sv | 26 ++
 rtl/mbr_bit_sync.sv | 44 ++++
 rtl/mbr_frame_rx.sv | 137 +++++++++++++
 tb/tb_mbr_frame_rx.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/mbr_pkg.sv
// Shared types and sizing helpers for the MBR frame receiver.
package mbr_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } mbr_state_t;

    localparam int MBR_FRAME_BITS_DEF = 40;

    // Good-marker and missed-marker run counters only need to reach 7.
    localparam int MBR_RUN_W = 3;

    // Bits needed to count 0..n-1.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mbr_frame_rx_if.sv
// Line-side inputs and word-side outputs of the MBR frame receiver.
import mbr_pkg::*;

interface mbr_frame_rx_if #(
    parameter int FRAME_BITS = MBR_FRAME_BITS_DEF
);
    logic                  i320;
    logic                  iMBR;
    logic                  iData;
    logic [FRAME_BITS-1:0] oWord;
    logic                  oValid;
    logic                  oLock;
    logic                  oErr;

    // Far end / stimulus side: drives the serial line, observes results.
    modport master (
        output i320, iMBR, iData,
        input  oWord, oValid, oLock, oErr
    );

    // Receiver side.
    modport slave (
        input  i320, iMBR, iData,
        output oWord, oValid, oLock, oErr
    );
endinterface

// File: rtl/mbr_bit_sync.sv
// Brings the asynchronous bit strobe, marker and data into the clk domain
// and turns each strobe rising edge into a single-cycle tick.
module mbr_bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic i320,
    input  logic mbr,
    input  logic data,
    output logic tick,
    output logic mbr_s,
    output logic data_s
);
    logic i320_p0, i320_p1, i320_p2;
    logic mbr_p0, mbr_p1;
    logic data_p0, data_p1;

    // Two-flop synchronizers; i320 gets a third flop as the edge-detect history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i320_p0 <= 1'b0;
            i320_p1 <= 1'b0;
            i320_p2 <= 1'b0;
            mbr_p0  <= 1'b1;
            mbr_p1  <= 1'b1;
            data_p0 <= 1'b0;
            data_p1 <= 1'b0;
        end else begin
            i320_p0 <= i320;
            i320_p1 <= i320_p0;
            i320_p2 <= i320_p1;
            mbr_p0  <= mbr;
            mbr_p1  <= mbr_p0;
            data_p0 <= data;
            data_p1 <= data_p0;
        end
    end

    // Marker and data travel through the same depth as the strobe, so they
    // are aligned with the tick they belong to.
    assign tick   = i320_p1 & ~i320_p2;
    assign mbr_s  = mbr_p1;
    assign data_s = data_p1;

endmodule

// File: rtl/mbr_frame_rx.sv
// MBR frame receiver: acquires alignment from the marker spacing, tracks
// lock, and deserializes each locked frame into a parallel word.
module mbr_frame_rx
    import mbr_pkg::*;
#(
    parameter int FRAME_BITS  = MBR_FRAME_BITS_DEF,
    parameter int SYNC_FRAMES = 2,
    parameter int MISS_LIMIT  = 2
) (
    input  logic           clk,
    input  logic           rst,
    mbr_frame_rx_if.slave  bus
);
    localparam int                   CW     = cnt_w(FRAME_BITS);
    localparam logic [CW-1:0]        LAST   = CW'(FRAME_BITS - 1);
    localparam logic [MBR_RUN_W-1:0] SYNC_N = MBR_RUN_W'(SYNC_FRAMES);
    localparam logic [MBR_RUN_W-1:0] MISS_N = MBR_RUN_W'(MISS_LIMIT);

    logic tick, mbr_s, data_s;

    mbr_state_t            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [MBR_RUN_W-1:0]  good_q, good_d, miss_q, miss_d;
    logic [MBR_RUN_W-1:0]  good_inc, miss_inc;
    logic [FRAME_BITS-1:0] shift_q, word_q;
    logic                  valid_q, valid_d, err_q, err_d, lock_q;
    logic                  load, slot;

    mbr_bit_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .i320   (bus.i320),
        .mbr    (bus.iMBR),
        .data   (bus.iData),
        .tick   (tick),
        .mbr_s  (mbr_s),
        .data_s (data_s)
    );

    // Next-state, counter and pulse decisions; everything holds unless a tick arrives.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        good_d   = good_q;
        miss_d   = miss_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        load     = 1'b0;
        slot     = (cnt_q == LAST);
        good_inc = good_q + 3'd1;
        miss_inc = miss_q + 3'd1;
        if (tick) begin
            // Any accepted marker restarts the count; otherwise free-run and wrap.
            cnt_d = (!mbr_s || slot) ? '0 : cnt_q + 1'b1;
            case (state_q)
                HUNT: begin
                    if (!mbr_s) begin
                        good_d  = 3'd1;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    if (slot) begin
                        if (!mbr_s) begin
                            good_d = good_inc;
                            if (good_inc >= SYNC_N) begin
                                state_d = LOCKED;
                                miss_d  = '0;
                            end
                        end else begin
                            state_d = HUNT;
                        end
                    end else if (!mbr_s) begin
                        good_d = 3'd1;
                    end
                end
                LOCKED: begin
                    if (slot) begin
                        if (!mbr_s) begin
                            load    = 1'b1;
                            valid_d = 1'b1;
                            miss_d  = '0;
                        end else begin
                            err_d  = 1'b1;
                            miss_d = miss_inc;
                            if (miss_inc >= MISS_N) state_d = HUNT;
                        end
                    end else if (!mbr_s) begin
                        // Marker off the expected slot: alignment is suspect.
                        err_d   = 1'b1;
                        good_d  = 3'd1;
                        state_d = VERIFY;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= HUNT;
        else      state_q <= state_d;
    end

    // Counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            good_q  <= '0;
            miss_q  <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            good_q  <= good_d;
            miss_q  <= miss_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            lock_q  <= (state_d == LOCKED);
            if (load) word_q <= {shift_q[FRAME_BITS-2:0], data_s};
        end
    end

    // Serial-to-parallel shifter; fully refilled before any word can be loaded.
    always_ff @(posedge clk) begin
        if (tick) shift_q <= {shift_q[FRAME_BITS-2:0], data_s};
    end

    assign bus.oWord  = word_q;
    assign bus.oValid = valid_q;
    assign bus.oLock  = lock_q;
    assign bus.oErr   = err_q;

endmodule

// File: tb/tb_mbr_frame_rx.sv
// Directed bench for mbr_frame_rx: frame-by-frame vector table plus a
// mid-frame reset sequence.
module tb_mbr_frame_rx;
    import mbr_pkg::*;

    localparam int FB = 40;

    localparam logic [FB-1:0] W3  = 40'hA5C30F965A;
    localparam logic [FB-1:0] W4  = 40'h123456789A;
    localparam logic [FB-1:0] W6  = 40'hFEDCBA9876;
    localparam logic [FB-1:0] W11 = 40'h0F1E2D3C4B;
    localparam logic [FB-1:0] W12 = 40'h3333CCCC55;
    localparam logic [FB-1:0] W13 = 40'h6B6B6B6B6B;
    localparam logic [FB-1:0] W14 = 40'hC0FFEE1234;
    localparam logic [FB-1:0] WB2 = 40'h5A5AC3C3E1;
    localparam logic [FB-1:0] WB3 = 40'h8000000001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mbr_frame_rx_if #(.FRAME_BITS(FB)) bus ();

    mbr_frame_rx #(
        .FRAME_BITS  (FB),
        .SYNC_FRAMES (2),
        .MISS_LIMIT  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // mpos: bit position (0..39) carrying the marker, 40 = no marker.
    typedef struct {
        int            mpos;
        logic [FB-1:0] data;
        bit            fast;
        int            ev;
        int            ee;
        logic          el;
        logic [FB-1:0] ew;
    } vec_t;

    vec_t va [14];
    vec_t vb [4];

    int            errors  = 0;
    int            checks  = 0;
    int            n_valid = 0;
    int            n_err   = 0;
    logic [FB-1:0] last_word = '0;

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.oValid) begin
            n_valid   <= n_valid + 1;
            last_word <= bus.oWord;
        end
        if (bus.oErr) n_err <= n_err + 1;
    end

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // One bit period: slow = 8 clk with strobe high 4 clk; fast = 4 clk, high 1 clk.
    task automatic send_bit(input logic m, input logic d, input bit fast);
        int per;
        int hi;
        per = fast ? 4 : 8;
        hi  = fast ? 1 : 4;
        bus.i320  = 1'b1;
        bus.iMBR  = m;
        bus.iData = d;
        repeat (hi) @(negedge clk);
        bus.i320 = 1'b0;
        repeat (per - hi) @(negedge clk);
    endtask

    task automatic run_vec(input string tag, input int idx, input vec_t v);
        int v0;
        int e0;
        v0 = n_valid;
        e0 = n_err;
        for (int p = 0; p < FB; p++)
            send_bit((p == v.mpos) ? 1'b0 : 1'b1, v.data[FB-1-p], v.fast);
        @(negedge clk);
        chk({tag, "_valid_cnt"}, idx, 64'(n_valid - v0), 64'(v.ev));
        chk({tag, "_err_cnt"}, idx, 64'(n_err - e0), 64'(v.ee));
        chk({tag, "_lock"}, idx, 64'(bus.oLock), 64'(v.el));
        if (v.ev != 0) chk({tag, "_word"}, idx, 64'(last_word), 64'(v.ew));
    endtask

    task automatic chk_outputs_zero(input int idx);
        chk("rst_oWord", idx, 64'(bus.oWord), 64'd0);
        chk("rst_oValid", idx, 64'(bus.oValid), 64'd0);
        chk("rst_oLock", idx, 64'(bus.oLock), 64'd0);
        chk("rst_oErr", idx, 64'(bus.oErr), 64'd0);
    endtask

    initial begin
        // Acquisition, single/double miss, relock, early marker.
        va[0]  = '{39, 40'h0000000000, 1'b0, 0, 0, 1'b0, '0};  // HUNT -> VERIFY
        va[1]  = '{39, 40'hFFFFFFFFFF, 1'b0, 0, 0, 1'b1, '0};  // good=2 -> LOCKED
        va[2]  = '{39, W3,             1'b0, 1, 0, 1'b1, W3};
        va[3]  = '{39, W4,             1'b0, 1, 0, 1'b1, W4};
        va[4]  = '{40, 40'h1111111111, 1'b0, 0, 1, 1'b1, '0};  // one miss
        va[5]  = '{39, W6,             1'b0, 1, 0, 1'b1, W6};
        va[6]  = '{40, 40'h2222222222, 1'b0, 0, 1, 1'b1, '0};  // miss 1
        va[7]  = '{40, 40'h4444444444, 1'b0, 0, 1, 1'b0, '0};  // miss 2 -> HUNT
        va[8]  = '{39, 40'h7777777777, 1'b0, 0, 0, 1'b0, '0};
        va[9]  = '{39, 40'h8888888888, 1'b0, 0, 0, 1'b1, '0};
        va[10] = '{39, W11,            1'b0, 1, 0, 1'b1, W11};
        va[11] = '{20, W12,            1'b0, 0, 1, 1'b0, '0};  // early marker
        va[12] = '{20, W13,            1'b0, 0, 0, 1'b1, '0};  // 40 ticks later
        va[13] = '{20, W14,            1'b0, 1, 0, 1'b1, {W13[18:0], W14[39:19]}};

        // After mid-frame reset; last two frames use the 1-clk-high strobe at clk/4.
        vb[0] = '{39, 40'hDEADBEEF01, 1'b0, 0, 0, 1'b0, '0};
        vb[1] = '{39, 40'h0123456789, 1'b0, 0, 0, 1'b1, '0};
        vb[2] = '{39, WB2,            1'b1, 1, 0, 1'b1, WB2};
        vb[3] = '{39, WB3,            1'b1, 1, 0, 1'b1, WB3};

        bus.i320  = 1'b0;
        bus.iMBR  = 1'b1;
        bus.iData = 1'b0;
        rst       = 1'b0;
        repeat (3) @(negedge clk);
        chk_outputs_zero(0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) run_vec("A", i, va[i]);

        // Reset while locked, partway into a frame.
        for (int p = 0; p < 17; p++) send_bit(1'b1, p[0], 1'b0);
        rst = 1'b0;
        #1;
        chk_outputs_zero(1);
        @(negedge clk);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_vec("B", i, vb[i]);
            if (i == 1) chk("B_word_still_zero", i, 64'(bus.oWord), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
